// File: rtl/axil_regfile.sv
// ---------------------------------------------------------------------------
// axil_regfile
//
// AXI4-Lite slave register bank. NUM_REGS word registers sit at consecutive
// word addresses starting at BASE_ADDR. Registers flagged in RO_MASK are
// read-only: reads return the matching hw_status slice and writes are refused
// with SLVERR. Every committed write to a writable register pulses the
// matching reg_wr_pulse bit for one cycle, as long as any strobe was set.
//
// The AW and W channels each have a one-entry holding register, so they can
// complete their handshakes in any order. A write commits once both are held
// and the B channel is free, or is being freed in that same cycle.
//
// Ports
//   clk, rst_n                    clock, synchronous active-low reset
//   axi_aw* / axi_w* / axi_b*     AXI4-Lite write address, data, response
//   axi_ar* / axi_r*              AXI4-Lite read address, data
//   reg_q                         flattened register contents, slice i = reg i
//   reg_wr_pulse                  one-cycle pulse per register on a commit
//   hw_status                     read values for the read-only registers
// ---------------------------------------------------------------------------
module axil_regfile #(
   parameter int unsigned             ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = ADDR_WIDTH'(32'h1000_0000),
   parameter int unsigned             NUM_REGS   = 8,
   parameter int unsigned             DATA_WIDTH = 32,
   parameter int unsigned             STRB_WIDTH = DATA_WIDTH / 8,
   parameter logic [NUM_REGS-1:0]     RO_MASK    = '0
) (
   input  logic                           clk,
   input  logic                           rst_n,

   input  logic [ADDR_WIDTH-1:0]          axi_awaddr,
   input  logic                           axi_awvalid,
   output logic                           axi_awready,
   input  logic [DATA_WIDTH-1:0]          axi_wdata,
   input  logic [STRB_WIDTH-1:0]          axi_wstrb,
   input  logic                           axi_wvalid,
   output logic                           axi_wready,
   output logic [1:0]                     axi_bresp,
   output logic                           axi_bvalid,
   input  logic                           axi_bready,

   input  logic [ADDR_WIDTH-1:0]          axi_araddr,
   input  logic                           axi_arvalid,
   output logic                           axi_arready,
   output logic [DATA_WIDTH-1:0]          axi_rdata,
   output logic [1:0]                     axi_rresp,
   output logic                           axi_rvalid,
   input  logic                           axi_rready,

   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
   output logic [NUM_REGS-1:0]            reg_wr_pulse,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status
);

   localparam int unsigned ADDR_LSB = $clog2(STRB_WIDTH);
   localparam int unsigned IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // A hit must lie at or above the base, be word aligned and fall inside the
   // bank. BASE_ADDR is itself aligned, so checking the raw address's low bits
   // is the same as checking the offset's low bits.
   function automatic logic decodeHit(input logic [ADDR_WIDTH-1:0] addr);
      logic [ADDR_WIDTH-1:0] offset;
      offset = addr - BASE_ADDR;
      return (addr >= BASE_ADDR) &&
             (addr[ADDR_LSB-1:0] == '0) &&
             ((offset >> ADDR_LSB) < NUM_REGS_A);
   endfunction

   // Register index of an address. Only meaningful when decodeHit is true.
   function automatic logic [IDX_W-1:0] decodeIdx(input logic [ADDR_WIDTH-1:0] addr);
      logic [ADDR_WIDTH-1:0] offset;
      offset = addr - BASE_ADDR;
      return offset[ADDR_LSB +: IDX_W];
   endfunction

   // Write channel state
   logic                  awHeld_q, awHeld_d;
   logic [ADDR_WIDTH-1:0] awAddr_q, awAddr_d;
   logic                  wHeld_q,  wHeld_d;
   logic [DATA_WIDTH-1:0] wData_q,  wData_d;
   logic [STRB_WIDTH-1:0] wStrb_q,  wStrb_d;
   logic                  bValid_q, bValid_d;
   logic [1:0]            bResp_q,  bResp_d;

   // Read channel state
   logic                  rValid_q, rValid_d;
   logic [DATA_WIDTH-1:0] rData_q,  rData_d;
   logic [1:0]            rResp_q,  rResp_d;

   // Register storage and write pulses
   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
   logic [NUM_REGS-1:0]   wrPulse_q, wrPulse_d;

   logic [DATA_WIDTH-1:0] hwStatus [NUM_REGS];

   logic                  awHs, wHs, arHs, commit;
   logic                  wrHit, wrOk, rdHit;
   logic [IDX_W-1:0]      wrIdx, rdIdx;

   for (genvar g = 0; g < NUM_REGS; g++) begin : gSlice
      assign hwStatus[g]                         = hw_status[g*DATA_WIDTH +: DATA_WIDTH];
      assign reg_q[g*DATA_WIDTH +: DATA_WIDTH]   = regs_q[g];
   end

   assign axi_awready  = ~awHeld_q;
   assign axi_wready   = ~wHeld_q;
   assign axi_bvalid   = bValid_q;
   assign axi_bresp    = bResp_q;
   // A new read may be accepted whenever the output slot is empty or is
   // being drained in this same cycle, which gives one read per cycle.
   assign axi_arready  = ~rValid_q | axi_rready;
   assign axi_rvalid   = rValid_q;
   assign axi_rdata    = rData_q;
   assign axi_rresp    = rResp_q;
   assign reg_wr_pulse = wrPulse_q;

   assign awHs   = axi_awvalid & ~awHeld_q;
   assign wHs    = axi_wvalid  & ~wHeld_q;
   assign arHs   = axi_arvalid & axi_arready;
   // The B slot is free if empty or if its current response is being
   // accepted now; in the latter case bvalid stays high with the new response.
   assign commit = awHeld_q & wHeld_q & (~bValid_q | axi_bready);

   assign wrHit  = decodeHit(awAddr_q);
   assign wrIdx  = decodeIdx(awAddr_q);
   assign wrOk   = wrHit && !RO_MASK[wrIdx];
   assign rdHit  = decodeHit(axi_araddr);
   assign rdIdx  = decodeIdx(axi_araddr);

   // Write path next state. A commit can never coincide with a new AW or W
   // handshake, because both holding registers must be full to commit and a
   // full holding register keeps its ready low.
   always_comb begin
      awHeld_d  = awHeld_q;
      awAddr_d  = awAddr_q;
      wHeld_d   = wHeld_q;
      wData_d   = wData_q;
      wStrb_d   = wStrb_q;
      bValid_d  = bValid_q;
      bResp_d   = bResp_q;
      regs_d    = regs_q;
      wrPulse_d = '0;

      if (awHs) begin
         awHeld_d = 1'b1;
         awAddr_d = axi_awaddr;
      end

      if (wHs) begin
         wHeld_d = 1'b1;
         wData_d = axi_wdata;
         wStrb_d = axi_wstrb;
      end

      if (commit) begin
         awHeld_d = 1'b0;
         wHeld_d  = 1'b0;
         bValid_d = 1'b1;
         bResp_d  = wrOk ? RESP_OKAY : RESP_SLVERR;
         if (wrOk) begin
            for (int b = 0; b < int'(STRB_WIDTH); b++) begin
               if (wStrb_q[b]) begin
                  regs_d[wrIdx][8*b +: 8] = wData_q[8*b +: 8];
               end
            end
            wrPulse_d[wrIdx] = |wStrb_q;
         end
      end else if (axi_bready) begin
         bValid_d = 1'b0;
      end
   end

   // Read path next state. The data is taken from the registers as they are
   // before this edge, so a read racing a commit to the same register returns
   // the old value.
   always_comb begin
      rValid_d = rValid_q;
      rData_d  = rData_q;
      rResp_d  = rResp_q;

      if (arHs) begin
         rValid_d = 1'b1;
         if (!rdHit) begin
            rData_d = '0;
            rResp_d = RESP_SLVERR;
         end else if (RO_MASK[rdIdx]) begin
            rData_d = hwStatus[rdIdx];
            rResp_d = RESP_OKAY;
         end else begin
            rData_d = regs_q[rdIdx];
            rResp_d = RESP_OKAY;
         end
      end else if (axi_rready) begin
         rValid_d = 1'b0;
      end
   end

   // Reset drops any held AW/W beat and any pending response outright.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         awHeld_q  <= 1'b0;
         awAddr_q  <= '0;
         wHeld_q   <= 1'b0;
         wData_q   <= '0;
         wStrb_q   <= '0;
         bValid_q  <= 1'b0;
         bResp_q   <= RESP_OKAY;
         rValid_q  <= 1'b0;
         rData_q   <= '0;
         rResp_q   <= RESP_OKAY;
         wrPulse_q <= '0;
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         awHeld_q  <= awHeld_d;
         awAddr_q  <= awAddr_d;
         wHeld_q   <= wHeld_d;
         wData_q   <= wData_d;
         wStrb_q   <= wStrb_d;
         bValid_q  <= bValid_d;
         bResp_q   <= bResp_d;
         rValid_q  <= rValid_d;
         rData_q   <= rData_d;
         rResp_q   <= rResp_d;
         wrPulse_q <= wrPulse_d;
         regs_q    <= regs_d;
      end
   end

endmodule

// File: tb/tb_axil_regfile.sv
// ---------------------------------------------------------------------------
// tb_axil_regfile
//
// Self-checking bench for axil_regfile (8 x 32-bit registers, register 7
// read-only). A word-level model of the bank (array of words, byte-mask
// merge, address arithmetic) predicts every response, pulse and read value.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_axil_regfile;

   localparam logic [31:0] BASE = 32'h1000_0000;
   localparam logic [7:0]  RO   = 8'h80;

   logic         clk;
   logic         rst_n;
   logic [31:0]  axi_awaddr;
   logic         axi_awvalid;
   logic         axi_awready;
   logic [31:0]  axi_wdata;
   logic [3:0]   axi_wstrb;
   logic         axi_wvalid;
   logic         axi_wready;
   logic [1:0]   axi_bresp;
   logic         axi_bvalid;
   logic         axi_bready;
   logic [31:0]  axi_araddr;
   logic         axi_arvalid;
   logic         axi_arready;
   logic [31:0]  axi_rdata;
   logic [1:0]   axi_rresp;
   logic         axi_rvalid;
   logic         axi_rready;
   logic [255:0] reg_q;
   logic [7:0]   reg_wr_pulse;
   logic [255:0] hw_status;

   int checks = 0;
   int errors = 0;

   logic [31:0] model [8];

   axil_regfile #(.RO_MASK(RO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .axi_awaddr   (axi_awaddr),
      .axi_awvalid  (axi_awvalid),
      .axi_awready  (axi_awready),
      .axi_wdata    (axi_wdata),
      .axi_wstrb    (axi_wstrb),
      .axi_wvalid   (axi_wvalid),
      .axi_wready   (axi_wready),
      .axi_bresp    (axi_bresp),
      .axi_bvalid   (axi_bvalid),
      .axi_bready   (axi_bready),
      .axi_araddr   (axi_araddr),
      .axi_arvalid  (axi_arvalid),
      .axi_arready  (axi_arready),
      .axi_rdata    (axi_rdata),
      .axi_rresp    (axi_rresp),
      .axi_rvalid   (axi_rvalid),
      .axi_rready   (axi_rready),
      .reg_q        (reg_q),
      .reg_wr_pulse (reg_wr_pulse),
      .hw_status    (hw_status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] simulation did not finish in time");
   end

   // ---------------- reference model ----------------
   function automatic bit isHit(input logic [31:0] a);
      return (a >= BASE) && (a % 4 == 0) && ((a - BASE) / 4 < 8);
   endfunction

   function automatic int idxOf(input logic [31:0] a);
      return int'((a - BASE) / 4);
   endfunction

   function automatic logic [1:0] writeResp(input logic [31:0] a);
      if (!isHit(a)) return 2'b10;
      if (RO[idxOf(a)]) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [1:0] readResp(input logic [31:0] a);
      return isHit(a) ? 2'b00 : 2'b10;
   endfunction

   function automatic logic [31:0] readData(input logic [31:0] a);
      if (!isHit(a)) return 32'h0;
      if (RO[idxOf(a)]) return hw_status[32*idxOf(a) +: 32];
      return model[idxOf(a)];
   endfunction

   function automatic logic [31:0] strbMask(input logic [3:0] s);
      return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
   endfunction

   function automatic logic [255:0] modelFlat();
      logic [255:0] f;
      for (int i = 0; i < 8; i++) f[32*i +: 32] = model[i];
      return f;
   endfunction

   // ---------------- checking ----------------
   task automatic checkOutput(input string tag, input logic [255:0] observed,
                              input logic [255:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Full write transaction with independent AW/W start delays; checks the
   // response, the pulse, the register image and the response latency.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input int awDelay,
                                input int wDelay, input string tag);
      logic [1:0] eResp;
      logic [7:0] ePulse;
      int         cyc;
      int         idx;
      bit         awDone, wDone, awFire, wFire;
      eResp  = writeResp(addr);
      idx    = idxOf(addr);
      ePulse = (eResp == 2'b00 && strb != 4'h0) ? 8'(1 << idx) : 8'h00;
      axi_bready = 1'b1;
      axi_awaddr = addr;
      axi_wdata  = data;
      axi_wstrb  = strb;
      awDone = 0; wDone = 0; cyc = 0;
      while (!(awDone && wDone) && cyc < 40) begin
         if (!awDone) axi_awvalid = (cyc >= awDelay);
         if (!wDone)  axi_wvalid  = (cyc >= wDelay);
         awFire = axi_awvalid && axi_awready;
         wFire  = axi_wvalid  && axi_wready;
         @(negedge clk);
         cyc++;
         if (awFire) begin awDone = 1; axi_awvalid = 1'b0; end
         if (wFire)  begin wDone  = 1; axi_wvalid  = 1'b0; end
         if (wDone && !awDone) checkOutput({tag, ".wready_held"}, axi_wready, 0);
      end
      axi_awvalid = 1'b0;
      axi_wvalid  = 1'b0;
      cyc = 0;
      while (!axi_bvalid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput({tag, ".bvalid"}, axi_bvalid, 1);
      checkOutput({tag, ".latency"}, cyc, 1);
      checkOutput({tag, ".bresp"}, axi_bresp, eResp);
      checkOutput({tag, ".pulse"}, reg_wr_pulse, ePulse);
      if (eResp == 2'b00)
         model[idx] = (model[idx] & ~strbMask(strb)) | (data & strbMask(strb));
      checkOutput({tag, ".reg_q"}, reg_q, modelFlat());
      @(negedge clk);
      checkOutput({tag, ".pulse_clr"}, reg_wr_pulse, 0);
      checkOutput({tag, ".bvalid_drop"}, axi_bvalid, 0);
   endtask

   task automatic readTxn(input logic [31:0] addr, input string tag);
      logic [31:0] eData;
      logic [1:0]  eResp;
      int          cyc;
      eData = readData(addr);
      eResp = readResp(addr);
      axi_rready  = 1'b1;
      axi_araddr  = addr;
      axi_arvalid = 1'b1;
      #1;
      cyc = 0;
      while (!axi_arready && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      @(negedge clk);
      axi_arvalid = 1'b0;
      checkOutput({tag, ".rvalid"}, axi_rvalid, 1);
      checkOutput({tag, ".rdata"}, axi_rdata, eData);
      checkOutput({tag, ".rresp"}, axi_rresp, eResp);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [31:0] preVal;
      logic [31:0] qData [$];
      logic [1:0]  qResp [$];
      logic [31:0] stData;
      logic [1:0]  stResp;
      logic [31:0] a;
      bit          stalled, arFire;
      int          issued, beats, cyc, r;

      rst_n = 1'b0;
      axi_awaddr = '0; axi_awvalid = 1'b0; axi_wdata = '0; axi_wstrb = '0;
      axi_wvalid = 1'b0; axi_bready = 1'b1; axi_araddr = '0;
      axi_arvalid = 1'b0; axi_rready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         model[i] = 32'h0;
         hw_status[32*i +: 32] = $urandom;
      end
      hw_status[32*7 +: 32] = 32'hCAFE_0001;

      repeat (3) @(negedge clk);
      checkOutput("rst.reg_q", reg_q, 0);
      checkOutput("rst.pulse", reg_wr_pulse, 0);
      checkOutput("rst.bvalid", axi_bvalid, 0);
      checkOutput("rst.rvalid", axi_rvalid, 0);
      checkOutput("rst.rdata", axi_rdata, 0);
      checkOutput("rst.bresp", axi_bresp, 0);
      checkOutput("rst.rresp", axi_rresp, 0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rst.awready", axi_awready, 1);
      checkOutput("rst.wready", axi_wready, 1);
      checkOutput("rst.arready", axi_arready, 1);

      // AW and W together
      applyStimulus(BASE + 32'h4, 32'hDEAD_BEEF, 4'hF, 0, 0, "tp1");
      checkOutput("tp1.reg1", reg_q[63:32], 32'hDEAD_BEEF);

      // W first, AW three cycles later, partial strobes
      applyStimulus(BASE + 32'h8, 32'h1122_3344, 4'h5, 3, 0, "tp2");
      checkOutput("tp2.reg2", reg_q[95:64], 32'h0022_0044);

      // Out of range, misaligned, below base
      applyStimulus(BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, 0, 0, "tp3.range");
      applyStimulus(BASE + 32'h2,  32'hFFFF_FFFF, 4'hF, 0, 1, "tp3.align");
      applyStimulus(BASE - 32'h4,  32'hFFFF_FFFF, 4'hF, 1, 0, "tp3.below");

      // Read-only register mapped to hw_status
      readTxn(BASE + 32'h1C, "tp4.rd1");
      applyStimulus(BASE + 32'h1C, 32'h1234_5678, 4'hF, 0, 0, "tp4.wr");
      readTxn(BASE + 32'h1C, "tp4.rd2");
      checkOutput("tp4.rdata", axi_rdata, 32'hCAFE_0001);

      // B channel back-pressure with a second write queued behind it
      axi_bready  = 1'b0;
      axi_awaddr  = BASE + 32'hC;  axi_awvalid = 1'b1;
      axi_wdata   = 32'hA5A5_0F0F; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
      @(negedge clk);
      axi_awvalid = 1'b0; axi_wvalid = 1'b0;
      @(negedge clk);
      checkOutput("tp5.bvalid1", axi_bvalid, 1);
      checkOutput("tp5.bresp1", axi_bresp, 0);
      checkOutput("tp5.pulse1", reg_wr_pulse, 8'h08);
      model[3] = 32'hA5A5_0F0F;
      checkOutput("tp5.reg_q1", reg_q, modelFlat());
      axi_awaddr  = BASE + 32'h10; axi_awvalid = 1'b1;
      axi_wdata   = 32'h0BAD_F00D; axi_wvalid = 1'b1;
      @(negedge clk);
      axi_awvalid = 1'b0; axi_wvalid = 1'b0;
      checkOutput("tp5.awready_held", axi_awready, 0);
      checkOutput("tp5.wready_held", axi_wready, 0);
      for (int i = 0; i < 5; i++) begin
         checkOutput("tp5.stall_bvalid", axi_bvalid, 1);
         checkOutput("tp5.stall_bresp", axi_bresp, 0);
         checkOutput("tp5.stall_pulse", reg_wr_pulse, 0);
         checkOutput("tp5.stall_reg_q", reg_q, modelFlat());
         @(negedge clk);
      end
      axi_bready = 1'b1;
      @(negedge clk);
      model[4] = 32'h0BAD_F00D;
      checkOutput("tp5.bvalid2", axi_bvalid, 1);
      checkOutput("tp5.bresp2", axi_bresp, 0);
      checkOutput("tp5.pulse2", reg_wr_pulse, 8'h10);
      checkOutput("tp5.reg_q2", reg_q, modelFlat());
      @(negedge clk);
      checkOutput("tp5.bvalid_drop", axi_bvalid, 0);

      // Back-to-back reads with rready held high
      axi_rready = 1'b1;
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) begin
            axi_araddr = BASE + 32'(4 * i);
            axi_arvalid = 1'b1;
            checkOutput("tp6.arready", axi_arready, 1);
         end else begin
            axi_arvalid = 1'b0;
         end
         if (i > 0) begin
            checkOutput("tp6.rvalid", axi_rvalid, 1);
            checkOutput("tp6.rdata", axi_rdata, readData(BASE + 32'(4 * (i - 1))));
            checkOutput("tp6.rresp", axi_rresp, 0);
         end
         @(negedge clk);
      end
      checkOutput("tp6.rvalid_drop", axi_rvalid, 0);

      // Same reads with rready toggling randomly
      issued = 0; beats = 0; cyc = 0; stalled = 0;
      stData = '0; stResp = '0;
      axi_araddr = BASE; axi_arvalid = 1'b1;
      while ((issued < 8 || qData.size() > 0) && cyc < 200) begin
         if (stalled) begin
            checkOutput("tg.stall_rvalid", axi_rvalid, 1);
            checkOutput("tg.stall_rdata", axi_rdata, stData);
            checkOutput("tg.stall_rresp", axi_rresp, stResp);
         end
         axi_rready = 1'($urandom_range(0, 1));
         #1;
         if (axi_rvalid && axi_rready) begin
            checkOutput("tg.beat_expected", 32'(qData.size()), 32'(qData.size() > 0 ? qData.size() : 1));
            if (qData.size() > 0) begin
               checkOutput("tg.rdata", axi_rdata, qData.pop_front());
               checkOutput("tg.rresp", axi_rresp, qResp.pop_front());
               beats++;
            end
         end
         stalled = axi_rvalid && !axi_rready;
         stData  = axi_rdata;
         stResp  = axi_rresp;
         arFire  = axi_arvalid && axi_arready;
         if (arFire) begin
            qData.push_back(readData(axi_araddr));
            qResp.push_back(readResp(axi_araddr));
            issued++;
         end
         @(negedge clk);
         cyc++;
         if (arFire) begin
            if (issued < 8) axi_araddr = BASE + 32'(4 * issued);
            else axi_arvalid = 1'b0;
         end
      end
      axi_arvalid = 1'b0;
      checkOutput("tg.beats", beats, 8);
      checkOutput("tg.rvalid_drop", axi_rvalid, 0);
      axi_rready = 1'b1;
      @(negedge clk);

      // Read and write commit to the same register in the same cycle
      preVal = model[1];
      axi_awaddr = BASE + 32'h4; axi_awvalid = 1'b1;
      axi_wdata = 32'h7777_8888; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
      @(negedge clk);
      axi_awvalid = 1'b0; axi_wvalid = 1'b0;
      axi_araddr = BASE + 32'h4; axi_arvalid = 1'b1;
      @(negedge clk);
      axi_arvalid = 1'b0;
      model[1] = 32'h7777_8888;
      checkOutput("race.rvalid", axi_rvalid, 1);
      checkOutput("race.rdata_old", axi_rdata, preVal);
      checkOutput("race.bvalid", axi_bvalid, 1);
      checkOutput("race.pulse", reg_wr_pulse, 8'h02);
      checkOutput("race.reg_q", reg_q, modelFlat());
      @(negedge clk);

      // Randomized mix of reads and writes
      for (int k = 0; k < 40; k++) begin
         r = $urandom_range(0, 9);
         a = BASE + 32'(4 * $urandom_range(0, 8));
         if (r == 0) a = a + 32'($urandom_range(1, 3));
         else if (r == 1) a = BASE - 32'(4 * $urandom_range(1, 4));
         if (k == 20) hw_status[32*7 +: 32] = $urandom;
         if ($urandom_range(0, 1) == 1)
            applyStimulus(a, $urandom, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 3), $urandom_range(0, 3), "rnd.wr");
         else
            readTxn(a, "rnd.rd");
      end

      // Reset with a W beat held: it must be discarded
      axi_wdata = 32'hFEED_FACE; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
      @(negedge clk);
      axi_wvalid = 1'b0;
      checkOutput("mrst.wready_held", axi_wready, 0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) model[i] = 32'h0;
      @(negedge clk);
      checkOutput("mrst.wready", axi_wready, 1);
      checkOutput("mrst.reg_q", reg_q, 0);
      checkOutput("mrst.bvalid", axi_bvalid, 0);
      applyStimulus(BASE, 32'h5A5A_5A5A, 4'hF, 0, 2, "mrst.wr");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axil_regfile.md
Name: axil_regfile

Overview:
- Parametrised AXI4-Lite slave register bank: NUM_REGS word registers at consecutive word addresses from BASE_ADDR.
- Replaces single-register AXI-Lite slaves used for core control/status.
- Adds independent AW/W acceptance, per-register read-only mapping to hardware status inputs, write-strobe pulses to consumers, and range/alignment decode with SLVERR.

Parameters:
- BASE_ADDR, 32'h10000000, byte address of register 0; aligned to STRB_WIDTH.
- NUM_REGS, 8, number of registers (1..256).
- DATA_WIDTH, 32, register and bus data width (32 or 64).
- ADDR_WIDTH, 32, AXI address width.
- STRB_WIDTH, DATA_WIDTH/8, write-strobe width.
- RO_MASK, {NUM_REGS{1'b0}}, bit i set: register i is read-only and reads hw_status slice i.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- axi_awaddr  in  ADDR_WIDTH  write address
- axi_awvalid  in  1  write address valid
- axi_awready  out  1  write address ready
- axi_wdata  in  DATA_WIDTH  write data
- axi_wstrb  in  STRB_WIDTH  byte strobes
- axi_wvalid  in  1  write data valid
- axi_wready  out  1  write data ready
- axi_bresp  out  2  write response
- axi_bvalid  out  1  write response valid
- axi_bready  in  1  write response ready
- axi_araddr  in  ADDR_WIDTH  read address
- axi_arvalid  in  1  read address valid
- axi_arready  out  1  read address ready
- axi_rdata  out  DATA_WIDTH  read data
- axi_rresp  out  2  read response
- axi_rvalid  out  1  read valid
- axi_rready  in  1  read ready
- reg_q  out  NUM_REGS*DATA_WIDTH  flattened register contents; slice i = reg i
- reg_wr_pulse  out  NUM_REGS  one-cycle pulse per register on committed write
- hw_status  in  NUM_REGS*DATA_WIDTH  read values for RO registers (other slices ignored)

Behaviour:
- Reset (synchronous, rst_n=0): reg_q, reg_wr_pulse, bvalid, rvalid, bresp, rresp, rdata = 0; awready = wready = 1 and arready = 1 in the first cycle after reset. Held AW/W and pending responses are discarded; reset mid-transaction needs no completion.
- Decode: hit iff addr >= BASE_ADDR, low log2(STRB_WIDTH) bits = 0, and (addr-BASE_ADDR)>>log2(STRB_WIDTH) < NUM_REGS. Miss -> SLVERR (2'b10); hit -> OKAY (2'b00).
- Write channel: separate one-entry holding regs aw_held/w_held. awready = !aw_held; wready = !w_held. Handshakes may occur in any order or the same cycle.
- Commit: in a cycle where aw_held & w_held & (!bvalid | bready). aw_held and w_held clear, and bvalid=1 with bresp set, on the next edge. Sustained throughput: 1 write per 2 cycles.
- Commit to a writable hit: reg_q bytes with strobe=1 update on the same edge bvalid rises. reg_wr_pulse[idx]=1 for exactly that one cycle, only if |wstrb.
- Commit to an RO register or a miss: SLVERR, no register change, no pulse.
- bvalid holds with stable bresp until bready. A commit in the same cycle as bready re-asserts bvalid with no gap.
- Read: arready = !rvalid | rready. AR handshake at cycle T -> rvalid at T+1.
  - rdata/rresp registered from cycle-T state: RO hit -> hw_status slice; RW hit -> reg_q slice; miss -> 0 and SLVERR.
  - rdata/rresp stable while rvalid & !rready. With rready held high, back-to-back reads run at 1 per cycle.
- Same-cycle read AR handshake and write commit to the same register: read returns the pre-write value.
- Read and write paths are fully independent; no ordering between them.

Test Plan:
- Reset, then AW+W same cycle to BASE+0x4, data 0xDEADBEEF, strb 0xF -> bvalid two cycles later, bresp=0; reg_q[63:32]=0xDEADBEEF; reg_wr_pulse=8'h02 for one cycle.
- W first, AW three cycles later, addr BASE+0x8, data 0x11223344, strb 0x5 over reset value 0 -> reg 2 = 0x00220044; wready low while W held.
- Write to BASE+0x20 (NUM_REGS=8), then to BASE+0x2 -> both bresp=2'b10; no reg_q change; no pulse.
- RO_MASK=8'h80, hw_status slice 7 = 0xCAFE0001 -> read BASE+0x1C returns 0xCAFE0001 OKAY; write there returns SLVERR and reads remain 0xCAFE0001.
- bready held low 5 cycles after a write -> bvalid/bresp stable; a second AW/W pair is accepted but not committed until bready.
- Back-to-back reads of regs 0..7 with rready=1 -> 8 rvalid beats on consecutive cycles. Repeat with rready toggling -> rdata stable while stalled, no beat lost or duplicated.
